// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RV32I decoder, ID/EX control register and load-use/redirect sequencer
// Define PIPE_CTRL_ILLEGAL_TRAP_EN to add ex_illegal/illegal_sticky reporting.
module pipe_ctrl #(
  parameter int ALUOP_W   = 5,
  parameter int NPCOP_W   = 5,
  parameter int EXTOP_W   = 6,
  parameter int FLUSH_CYC = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [31:0]        id_instr,
  input  logic               id_valid,
  input  logic [4:0]         ex_rd,
  input  logic               ex_memread,
  input  logic               ex_redirect,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               ifid_flush,
  output logic               ex_valid_o,
  output logic               ex_RegWrite,
  output logic               ex_MemWrite,
  output logic               ex_MemRead,
  output logic               ex_ALUSrc,
  output logic [1:0]         ex_WDSel,
  output logic [EXTOP_W-1:0] ex_EXTOp,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [NPCOP_W-1:0] ex_NPCOp,
  output logic [2:0]         ex_Funct3
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic               ex_illegal,
  output logic               illegal_sticky
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AUIPC = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_BNE   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_BLT   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_BGE   = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_BLTU  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_BGEU  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(12);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(13);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(14);
  localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(15);
  localparam logic [ALUOP_W-1:0] ALU_SRL   = ALUOP_W'(16);
  localparam logic [ALUOP_W-1:0] ALU_SRA   = ALUOP_W'(17);

  localparam logic [NPCOP_W-1:0] NPC_BRANCH = NPCOP_W'(5'b00001);
  localparam logic [NPCOP_W-1:0] NPC_JUMP   = NPCOP_W'(5'b00010);
  localparam logic [NPCOP_W-1:0] NPC_JALR   = NPCOP_W'(5'b00100);

  localparam logic [EXTOP_W-1:0] EXT_SHAMT = EXTOP_W'(6'b100000);
  localparam logic [EXTOP_W-1:0] EXT_I     = EXTOP_W'(6'b010000);
  localparam logic [EXTOP_W-1:0] EXT_S     = EXTOP_W'(6'b001000);
  localparam logic [EXTOP_W-1:0] EXT_B     = EXTOP_W'(6'b000100);
  localparam logic [EXTOP_W-1:0] EXT_U     = EXTOP_W'(6'b000010);
  localparam logic [EXTOP_W-1:0] EXT_J     = EXTOP_W'(6'b000001);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYC - 1);

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_write;
    logic               mem_read;
    logic               alu_src;
    logic [1:0]         wd_sel;
    logic [EXTOP_W-1:0] ext_op;
    logic [ALUOP_W-1:0] alu_op;
    logic [NPCOP_W-1:0] npc_op;
    logic [2:0]         funct3;
  } ctrl_t;

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       alt;
  logic       unused_rd;

  assign opcode    = id_instr[6:0];
  assign funct3    = id_instr[14:12];
  assign funct7    = id_instr[31:25];
  assign rs1       = id_instr[19:15];
  assign rs2       = id_instr[24:20];
  assign alt       = (funct7 == 7'h20);
  assign unused_rd = ^id_instr[11:7];

  ctrl_t  dec;
  logic   use_rs1;
  logic   use_rs2;

  // dec.valid doubles as the "recognised encoding" flag; other fields are masked later.
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_REG: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.reg_write = 1'b1;
        dec.valid     = (funct7 == 7'h00) || (alt && (funct3 == 3'b000 || funct3 == 3'b101));
        case (funct3)
          3'b000:  dec.alu_op = alt ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu_op = ALU_SLL;
          3'b010:  dec.alu_op = ALU_SLT;
          3'b011:  dec.alu_op = ALU_SLTU;
          3'b100:  dec.alu_op = ALU_XOR;
          3'b101:  dec.alu_op = alt ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
      end
      OP_IMM: begin
        use_rs1       = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_I;
        dec.valid     = 1'b1;
        case (funct3)
          3'b000:  dec.alu_op = ALU_ADD;
          3'b010:  dec.alu_op = ALU_SLT;
          3'b011:  dec.alu_op = ALU_SLTU;
          3'b100:  dec.alu_op = ALU_XOR;
          3'b110:  dec.alu_op = ALU_OR;
          3'b111:  dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op = ALU_SLL;
            dec.ext_op = EXT_SHAMT;
            dec.valid  = (funct7 == 7'h00);
          end
          default: begin
            dec.alu_op = alt ? ALU_SRA : ALU_SRL;
            dec.ext_op = EXT_SHAMT;
            dec.valid  = (funct7 == 7'h00) || alt;
          end
        endcase
      end
      OP_LOAD: begin
        use_rs1       = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_src   = 1'b1;
        dec.wd_sel    = 2'b01;
        dec.ext_op    = EXT_I;
        dec.alu_op    = ALU_ADD;
        dec.funct3    = funct3;
        dec.valid     = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OP_STORE: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_S;
        dec.alu_op    = ALU_ADD;
        dec.funct3    = funct3;
        dec.valid     = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
      end
      OP_BRANCH: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.ext_op = EXT_B;
        dec.npc_op = NPC_BRANCH;
        dec.valid  = (funct3 != 3'b010) && (funct3 != 3'b011);
        case (funct3)
          3'b000:  dec.alu_op = ALU_SUB;
          3'b001:  dec.alu_op = ALU_BNE;
          3'b100:  dec.alu_op = ALU_BLT;
          3'b101:  dec.alu_op = ALU_BGE;
          3'b110:  dec.alu_op = ALU_BLTU;
          default: dec.alu_op = ALU_BGEU;
        endcase
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.wd_sel    = 2'b10;
        dec.npc_op    = NPC_JUMP;
        dec.ext_op    = EXT_J;
        dec.valid     = 1'b1;
      end
      OP_JALR: begin
        use_rs1       = 1'b1;
        dec.reg_write = 1'b1;
        dec.wd_sel    = 2'b10;
        dec.npc_op    = NPC_JALR;
        dec.ext_op    = EXT_I;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.valid     = (funct3 == 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = EXT_U;
        dec.alu_op    = (opcode == OP_LUI) ? ALU_LUI : ALU_AUIPC;
        dec.valid     = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  state_t     state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  ctrl_t      bundle_q, bundle_d;
  logic       load_use;
  logic       stall_now;
  logic       flush_now;
  logic       capture;

  assign load_use = id_valid && bundle_q.valid && ex_memread && (ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

  // Hold and flush enables must act in the very cycle the hazard is seen, so they follow the live inputs.
  assign stall_now  = (state_q == S_RUN) && load_use && !ex_redirect;
  assign flush_now  = ex_redirect || (state_q == S_FLUSH);
  assign capture    = id_valid && dec.valid && !stall_now && !flush_now;
  assign pc_we      = !stall_now;
  assign ifid_we    = !stall_now;
  assign ifid_flush = flush_now;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    bundle_d    = capture ? dec : '0;
    if (ex_redirect) begin
      state_d     = (FLUSH_LOAD == 2'd0) ? S_RUN : S_FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      case (state_q)
        S_RUN:   if (load_use) state_d = S_STALL;
        S_STALL: state_d = S_RUN;
        default: begin
          flush_cnt_d = flush_cnt_q - 2'd1;
          if (flush_cnt_q <= 2'd1) state_d = S_RUN;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
  logic ex_illegal_q, ex_illegal_d;
  logic illegal_sticky_q, illegal_sticky_d;

  assign ex_illegal_d     = id_valid && !dec.valid && !stall_now && !flush_now;
  assign illegal_sticky_d = illegal_sticky_q || ex_illegal_d;
  assign ex_illegal       = ex_illegal_q;
  assign illegal_sticky   = illegal_sticky_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= S_RUN;
      flush_cnt_q      <= 2'd0;
      bundle_q         <= '0;
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
      ex_illegal_q     <= 1'b0;
      illegal_sticky_q <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      bundle_q         <= bundle_d;
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
      ex_illegal_q     <= ex_illegal_d;
      illegal_sticky_q <= illegal_sticky_d;
`endif
    end
  end

  assign ex_valid_o  = bundle_q.valid;
  assign ex_RegWrite = bundle_q.reg_write;
  assign ex_MemWrite = bundle_q.mem_write;
  assign ex_MemRead  = bundle_q.mem_read;
  assign ex_ALUSrc   = bundle_q.alu_src;
  assign ex_WDSel    = bundle_q.wd_sel;
  assign ex_EXTOp    = bundle_q.ext_op;
  assign ex_ALUOp    = bundle_q.alu_op;
  assign ex_NPCOp    = bundle_q.npc_op;
  assign ex_Funct3   = bundle_q.funct3;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized checks of pipe_ctrl against an instruction-level model
module tb_pipe_ctrl;
  localparam int FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic        ex_redirect;
  logic        pc_we, ifid_we, ifid_flush;
  logic        ex_valid_o, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc;
  logic [1:0]  ex_WDSel;
  logic [5:0]  ex_EXTOp;
  logic [4:0]  ex_ALUOp;
  logic [4:0]  ex_NPCOp;
  logic [2:0]  ex_Funct3;
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
  logic        ex_illegal, illegal_sticky;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.ALUOP_W(5), .NPCOP_W(5), .EXTOP_W(6), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rstn(rstn), .id_instr(id_instr), .id_valid(id_valid),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .ex_valid_o(ex_valid_o), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
    .ex_MemRead(ex_MemRead), .ex_ALUSrc(ex_ALUSrc), .ex_WDSel(ex_WDSel),
    .ex_EXTOp(ex_EXTOp), .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp), .ex_Funct3(ex_Funct3)
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    , .ex_illegal(ex_illegal), .illegal_sticky(illegal_sticky)
`endif
  );

  typedef struct packed {
    bit ok; bit rw; bit mw; bit mr; bit as;
    int wd; int ext; int alu; int npc; int f3;
    bit r1; bit r2;
  } dec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-set level reference: operation codes come from small per-funct3 tables.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    int   r_alu [8];
    int   b_alu [8];
    int   op, f3, f7;
    bit   alt;
    dec_t d;
    r_alu = '{3, 15, 10, 11, 12, 16, 13, 14};
    b_alu = '{4, 5, 0, 0, 6, 7, 8, 9};
    op  = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    alt = (f7 == 'h20);
    d   = '0;
    case (op)
      'h33: begin
        d.r1 = 1; d.r2 = 1; d.rw = 1;
        d.alu = r_alu[f3] + (alt ? 1 : 0);
        d.ok  = (f7 == 0) || (alt && (f3 == 0 || f3 == 5));
      end
      'h13: begin
        d.r1 = 1; d.rw = 1; d.as = 1; d.ext = 'h10; d.alu = r_alu[f3]; d.ok = 1;
        if (f3 == 1) begin d.ext = 'h20; d.ok = (f7 == 0); end
        if (f3 == 5) begin d.ext = 'h20; d.ok = (f7 == 0) || alt; d.alu = alt ? 17 : 16; end
      end
      'h03: begin
        d.r1 = 1; d.rw = 1; d.mr = 1; d.as = 1; d.wd = 1; d.ext = 'h10; d.alu = 3; d.f3 = f3;
        d.ok = ((32'h37 >> f3) & 1) == 1;
      end
      'h23: begin
        d.r1 = 1; d.r2 = 1; d.mw = 1; d.as = 1; d.ext = 'h08; d.alu = 3; d.f3 = f3;
        d.ok = (f3 < 3);
      end
      'h63: begin
        d.r1 = 1; d.r2 = 1; d.ext = 'h04; d.npc = 1; d.alu = b_alu[f3];
        d.ok = (f3 != 2) && (f3 != 3);
      end
      'h6F: begin d.rw = 1; d.wd = 2; d.npc = 2; d.ext = 1; d.ok = 1; end
      'h67: begin
        d.r1 = 1; d.rw = 1; d.wd = 2; d.npc = 4; d.ext = 'h10; d.as = 1; d.alu = 3;
        d.ok = (f3 == 0);
      end
      'h37: begin d.rw = 1; d.as = 1; d.ext = 2; d.alu = 1; d.ok = 1; end
      'h17: begin d.rw = 1; d.as = 1; d.ext = 2; d.alu = 2; d.ok = 1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [25:0] pack_exp(input dec_t d, input bit take);
    if (!take) return '0;
    return {1'b1, d.rw, d.mw, d.mr, d.as, 2'(d.wd), 6'(d.ext), 5'(d.alu), 5'(d.npc), 3'(d.f3)};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7, op;
    int k;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    k   = $urandom_range(0, 3);
    f7  = (k == 0) ? 7'h20 : (k == 1) ? 7'($urandom) : 7'h00;
    case ($urandom_range(0, 10))
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: op = 7'h23;
      4: op = 7'h63;
      5: op = 7'h6F;
      6: op = 7'h67;
      7: op = 7'h37;
      8: op = 7'h17;
      9: op = 7'($urandom);
      default: return $urandom;
    endcase
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  logic [25:0] act_bundle;
  assign act_bundle = {ex_valid_o, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc,
                       ex_WDSel, ex_EXTOp, ex_ALUOp, ex_NPCOp, ex_Funct3};

  bit          m_ex_valid, m_stalled, m_sticky;
  int          m_flush_left;
  dec_t        d;
  bit          lu, stall, flush, take, ill;
  logic [25:0] exp_bundle;

  initial begin
    rstn = 1'b0; id_instr = '0; id_valid = 1'b0; ex_rd = '0; ex_memread = 1'b0; ex_redirect = 1'b0;
    #2;
    chk("reset_bundle", 32'(act_bundle), 32'h0);
    chk("reset_pc_we", 32'(pc_we), 32'h1);
    chk("reset_ifid_we", 32'(ifid_we), 32'h1);
    chk("reset_ifid_flush", 32'(ifid_flush), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;

    // add x3,x1,x2
    id_instr = 32'h002081B3; id_valid = 1'b1;
    @(posedge clk); #1;
    chk("add_aluop", 32'(ex_ALUOp), 32'd3);
    chk("add_regwrite", 32'(ex_RegWrite), 32'h1);
    chk("add_alusrc", 32'(ex_ALUSrc), 32'h0);
    chk("add_wdsel", 32'(ex_WDSel), 32'h0);
    chk("add_valid", 32'(ex_valid_o), 32'h1);

    // load-use: EX lw x5, ID add x6,x5,x1
    @(negedge clk); id_instr = 32'h00128333; ex_memread = 1'b1; ex_rd = 5'd5; #1;
    chk("lu_pc_we", 32'(pc_we), 32'h0);
    chk("lu_ifid_we", 32'(ifid_we), 32'h0);
    @(posedge clk); #1;
    chk("lu_bubble_valid", 32'(ex_valid_o), 32'h0);
    chk("lu_bubble_regwrite", 32'(ex_RegWrite), 32'h0);
    @(negedge clk); #1;
    chk("lu_release_pc_we", 32'(pc_we), 32'h1);
    @(posedge clk); #1;
    chk("lu_add_valid", 32'(ex_valid_o), 32'h1);
    chk("lu_add_aluop", 32'(ex_ALUOp), 32'd3);

    // ex_rd = 0 never stalls: add x6,x0,x1
    @(negedge clk); ex_rd = 5'd0; id_instr = 32'h00100333; #1;
    chk("rd0_pc_we", 32'(pc_we), 32'h1);
    chk("rd0_ifid_we", 32'(ifid_we), 32'h1);
    @(posedge clk); #1;
    chk("rd0_valid", 32'(ex_valid_o), 32'h1);

    // redirect and load-use together, FLUSH_CYC=2
    @(negedge clk); ex_rd = 5'd5; id_instr = 32'h00128333; ex_redirect = 1'b1; #1;
    chk("rdir_flush0", 32'(ifid_flush), 32'h1);
    chk("rdir_pc_we0", 32'(pc_we), 32'h1);
    chk("rdir_ifid_we0", 32'(ifid_we), 32'h1);
    @(posedge clk); #1;
    chk("rdir_bubble0", 32'(act_bundle), 32'h0);
    @(negedge clk); ex_redirect = 1'b0; #1;
    chk("rdir_flush1", 32'(ifid_flush), 32'h1);
    chk("rdir_pc_we1", 32'(pc_we), 32'h1);
    @(posedge clk); #1;
    chk("rdir_bubble1", 32'(act_bundle), 32'h0);
    @(negedge clk); #1;
    chk("rdir_flush_end", 32'(ifid_flush), 32'h0);
    chk("rdir_pc_we2", 32'(pc_we), 32'h1);
    @(posedge clk); #1;
    chk("rdir_resume_valid", 32'(ex_valid_o), 32'h1);

    // jalr x1,0(x2)
    @(negedge clk); ex_memread = 1'b0; id_instr = 32'h000100E7;
    @(posedge clk); #1;
    chk("jalr_npcop", 32'(ex_NPCOp), 32'h04);
    chk("jalr_wdsel", 32'(ex_WDSel), 32'h2);
    chk("jalr_extop", 32'(ex_EXTOp), 32'h10);
    chk("jalr_alusrc", 32'(ex_ALUSrc), 32'h1);

    // async reset with lw x5,0(x1) in EX
    @(negedge clk); id_instr = 32'h0000A283;
    @(posedge clk); #1;
    chk("lw_memread", 32'(ex_MemRead), 32'h1);
    chk("lw_funct3", 32'(ex_Funct3), 32'h2);
    @(negedge clk); rstn = 1'b0; ex_memread = 1'b1; #1;
    chk("async_memread", 32'(ex_MemRead), 32'h0);
    chk("async_valid", 32'(ex_valid_o), 32'h0);
    chk("async_pc_we", 32'(pc_we), 32'h1);
    @(negedge clk); rstn = 1'b1; ex_memread = 1'b0;

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    chk("ill_reset_sticky", 32'(illegal_sticky), 32'h0);
    id_instr = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("ill_flag", 32'(ex_illegal), 32'h1);
    chk("ill_sticky", 32'(illegal_sticky), 32'h1);
    chk("ill_valid", 32'(ex_valid_o), 32'h0);
    @(negedge clk); id_instr = 32'h002081B3;
    @(posedge clk); #1;
    chk("ill_flag_clear", 32'(ex_illegal), 32'h0);
    chk("ill_sticky_hold", 32'(illegal_sticky), 32'h1);
    @(negedge clk); rstn = 1'b0; #1;
    chk("ill_sticky_reset", 32'(illegal_sticky), 32'h0);
    @(negedge clk); rstn = 1'b1;
`else
    id_instr = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("ill_nop_bundle", 32'(act_bundle), 32'h0);
`endif

    // randomized run against the model
    @(negedge clk); rstn = 1'b0; id_valid = 1'b0; ex_redirect = 1'b0;
    @(negedge clk); rstn = 1'b1;
    m_ex_valid = 0; m_stalled = 0; m_flush_left = 0; m_sticky = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      id_instr    = gen_instr();
      id_valid    = ($urandom_range(0, 7) != 0);
      ex_rd       = 5'($urandom_range(0, 7));
      ex_memread  = ($urandom_range(0, 1) == 1);
      ex_redirect = ($urandom_range(0, 9) == 0);
      #1;
      d     = ref_decode(id_instr);
      lu    = id_valid && m_ex_valid && ex_memread && (ex_rd != 0) &&
              ((d.r1 && id_instr[19:15] == ex_rd) || (d.r2 && id_instr[24:20] == ex_rd));
      stall = !ex_redirect && (m_flush_left == 0) && !m_stalled && lu;
      flush = ex_redirect || (m_flush_left > 0);
      take  = id_valid && d.ok && !stall && !flush;
      ill   = id_valid && !d.ok && !stall && !flush;
      exp_bundle = pack_exp(d, take);
      chk("rnd_pc_we", 32'(pc_we), 32'(!stall));
      chk("rnd_ifid_we", 32'(ifid_we), 32'(!stall));
      chk("rnd_ifid_flush", 32'(ifid_flush), 32'(flush));
      @(posedge clk); #1;
      if (ex_redirect) m_flush_left = FLUSH_CYC - 1;
      else if (m_flush_left > 0) m_flush_left--;
      m_stalled  = stall;
      m_ex_valid = take;
      m_sticky   = m_sticky || ill;
      chk("rnd_bundle", 32'(act_bundle), 32'(exp_bundle));
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
      chk("rnd_illegal", 32'(ex_illegal), 32'(ill));
      chk("rnd_sticky", 32'(illegal_sticky), 32'(m_sticky));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Next-generation RV32I control unit for the 5-stage pipelined CPU.
- Decodes the full RV32I base set in ID and registers the control bundle into the ID/EX boundary.
- Owns load-use stall and taken-branch/jump flush sequencing.
- Drives PC/IF-ID write-enables.

Parameters:
ALUOP_W, 5, ALUOp width; codes per ctrl_encode_def
NPCOP_W, 5, NPCOp width (PLUS4 00000, BRANCH 00001, JUMP 00010, JALR 00100)
EXTOP_W, 6, EXTOp one-hot width (ITYPE_SHAMT 100000, ITYPE 010000, STYPE 001000, BTYPE 000100, UTYPE 000010, JTYPE 000001)
FLUSH_CYC, 1, bubbles inserted after a redirect (1..3)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
id_instr  in  32  instruction in ID
id_valid  in  1  ID holds a real instruction
ex_rd  in  5  rd of instruction in EX
ex_memread  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved taken branch, JAL or JALR
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  clear IF/ID to bubble
ex_valid_o  out  1  registered: EX slot holds a real instruction
ex_RegWrite  out  1  registered
ex_MemWrite  out  1  registered
ex_MemRead  out  1  registered
ex_ALUSrc  out  1  registered
ex_WDSel  out  2  registered; 00 ALU, 01 MEM, 10 PC+4
ex_EXTOp  out  EXTOP_W  registered
ex_ALUOp  out  ALUOP_W  registered
ex_NPCOp  out  NPCOP_W  registered
ex_Funct3  out  3  registered; load/store width for the data-memory path

Behaviour:
- Reset (rstn low, async): all ex_* outputs 0 (bubble); pc_we=1, ifid_we=1, ifid_flush=0; FSM=RUN; flush counter 0.
- Decode is combinational on id_instr. Latency: the bundle appears on ex_* one clk edge after capture.

Decode coverage:
- R-type: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
- I-ALU: addi, slti, sltiu, xori, ori, andi; slli/srli/srai use EXTOp=ITYPE_SHAMT.
- Loads: lb, lh, lw, lbu, lhu (MemRead, WDSel=01).
- Stores: sb, sh, sw.
- Branches: beq→ALUOp sub; bne/blt/bge/bltu/bgeu→own codes; NPCOp=BRANCH; RegWrite=0.
- jal: NPCOp=JUMP, WDSel=10.
- jalr: NPCOp=JALR, WDSel=10, ALUSrc=1.
- lui: ALUOp=lui, UTYPE. auipc: ALUOp=auipc, UTYPE.

ALUOp codes:
- nop 0, lui 1, auipc 2, add 3, sub 4, bne 5, blt 6, bge 7, bltu 8, bgeu 9, slt 10, sltu 11, xor 12, or 13, and 14, sll 15, srl 16, sra 17.

Unmatched encodings:
- Decode to an all-zero bundle (NOP).

Hazard detection:
- load_use = id_valid & ex_valid_o & ex_memread & ex_rd≠0 & (rs1 or rs2 of id_instr equals ex_rd, counted only if that field is used by the format).
- U/J formats use neither field. I-type and loads use rs1 only.

FSM:
- RUN → STALL on load_use: pc_we=0, ifid_we=0, bubble into EX.
- STALL → RUN after exactly one cycle; the held instruction is then re-decoded.
- RUN/STALL → FLUSH on ex_redirect:
  - ifid_flush=1, bubble into EX, counter loads FLUSH_CYC-1.
  - pc_we=1 so the target is loaded.
- FLUSH: holds ifid_flush=1 and bubbles until counter reaches 0, then returns to RUN.
- FLUSH entry needs no memory of prior state.

Simultaneous events:
- ex_redirect beats load_use (the stalled instruction is on the wrong path).
- ex_redirect during FLUSH restarts the counter.

Bubble rule:
- Bubble = all ex_* 0 including ex_valid_o.
- id_valid=0 also injects a bubble.
- Bubbles never assert RegWrite/MemWrite.

Optional Feature:
Macro PIPE_CTRL_ILLEGAL_TRAP_EN.
- Enabled: adds outputs ex_illegal (1, registered, set with the bubble of an unmatched valid instruction) and illegal_sticky (1, set on first illegal, cleared only by reset). Both are 0 at reset. ex_valid_o=0 for that slot.
- Disabled: no extra ports; illegal instructions silently become NOPs.

Test Plan:
- Reset mid-run: pulse rstn low with a lw bundle in EX → ex_MemRead=0 immediately (async), pc_we=1.
- add x3,x1,x2 (0x002081B3), id_valid=1 → next cycle ex_ALUOp=3, ex_RegWrite=1, ex_ALUSrc=0, ex_WDSel=00.
- Load-use: EX holds lw to x5 (ex_memread=1, ex_rd=5); ID holds add x6,x5,x1 → one cycle pc_we=0, ifid_we=0, EX bubble; next cycle add reaches EX. With ex_rd=0 → no stall.
- Redirect over stall: load_use and ex_redirect in the same cycle, FLUSH_CYC=2 → ifid_flush=1 for 2 cycles, pc_we=1, two bubbles, no stall.
- jalr x1,0(x2) (0x000100E7) → ex_NPCOp=00100, ex_WDSel=10, ex_EXTOp=010000, ex_ALUSrc=1.
- With PIPE_CTRL_ILLEGAL_TRAP_EN: id_instr=0xFFFFFFFF → ex_illegal=1 for one cycle, illegal_sticky stays 1 until rstn low.
